// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for an external 10-bit up/down counter.
// The counter runs from a start point between two bounds for a set number of sweeps.
module counter_sweep_ctrl #(
   parameter logic [9:0] PRESET_VAL = 10'd253
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start_in,
   input  logic       abort_in,
   input  logic       start_sel_in,
   input  logic [9:0] lo_in,
   input  logic [9:0] hi_in,
   input  logic [3:0] cycles_in,
   input  logic [9:0] count_in,
   output logic       cnt_rst_out,
   output logic       cnt_preset_out,
   output logic       cnt_updown_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       err_out,
   output logic [3:0] sweep_cnt_out
);

   typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

   state_t     state_q, state_d;
   logic [9:0] lo_q, lo_d;
   logic [9:0] hi_q, hi_d;
   logic [3:0] cycles_q, cycles_d;
   logic       sel_q, sel_d;
   logic [3:0] sweep_d;
   logic       rst_d, preset_d, updown_d;
   logic       busy_d, done_d, err_d;
   logic [9:0] start_pt;
   logic       start_ok;
   logic [3:0] sweep_inc;

   assign start_pt  = start_sel_in ? PRESET_VAL : 10'd0;
   assign start_ok  = (lo_in < hi_in) && (lo_in <= start_pt)
                   && (start_pt < hi_in) && (cycles_in != 4'd0);
   assign sweep_inc = sweep_cnt_out + 4'd1;

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      cycles_d = cycles_q;
      sel_d    = sel_q;
      sweep_d  = sweep_cnt_out;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_in) begin
               sweep_d = 4'd0;
               if (start_ok) begin
                  lo_d     = lo_in;
                  hi_d     = hi_in;
                  cycles_d = cycles_in;
                  sel_d    = start_sel_in;
                  state_d  = LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         LOAD: state_d = abort_in ? IDLE : UP;
         UP: begin
            if (abort_in)
               state_d = IDLE;
            else if (count_in == hi_q - 10'd1)
               state_d = DOWN;
         end
         DOWN: begin
            // abort takes priority over the turn at the lower bound
            if (abort_in)
               state_d = IDLE;
            else if (count_in == lo_q + 10'd1) begin
               sweep_d = sweep_inc;
               state_d = (sweep_inc == cycles_q) ? DONE : UP;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs are decoded from the next state so they register with it
   always_comb begin
      rst_d    = 1'b1;
      preset_d = 1'b0;
      updown_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      unique case (state_d)
         IDLE: rst_d = 1'b1;
         LOAD: begin
            rst_d    = ~sel_d;
            preset_d = sel_d;
            updown_d = 1'b1;
            busy_d   = 1'b1;
         end
         UP: begin
            rst_d    = 1'b0;
            updown_d = 1'b1;
            busy_d   = 1'b1;
         end
         DOWN: begin
            rst_d  = 1'b0;
            busy_d = 1'b1;
         end
         DONE: done_d = 1'b1;
         default: rst_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= IDLE;
         lo_q           <= 10'd0;
         hi_q           <= 10'd0;
         cycles_q       <= 4'd0;
         sel_q          <= 1'b0;
         sweep_cnt_out  <= 4'd0;
         cnt_rst_out    <= 1'b1;
         cnt_preset_out <= 1'b0;
         cnt_updown_out <= 1'b0;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         state_q        <= state_d;
         lo_q           <= lo_d;
         hi_q           <= hi_d;
         cycles_q       <= cycles_d;
         sel_q          <= sel_d;
         sweep_cnt_out  <= sweep_d;
         cnt_rst_out    <= rst_d;
         cnt_preset_out <= preset_d;
         cnt_updown_out <= updown_d;
         busy_out       <= busy_d;
         done_out       <= done_d;
         err_out        <= err_d;
      end
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl with a behavioural counter and
// an expected count trajectory built from the sweep rules.
module tb_counter_sweep_ctrl;

   localparam logic [9:0] PRESET = 10'd253;

   logic       clk = 1'b0;
   logic       rst_in = 1'b1;
   logic       start_in = 1'b0;
   logic       abort_in = 1'b0;
   logic       start_sel_in = 1'b0;
   logic [9:0] lo_in = '0;
   logic [9:0] hi_in = '0;
   logic [3:0] cycles_in = '0;
   logic [9:0] count = '0;
   logic       cnt_rst_out, cnt_preset_out, cnt_updown_out;
   logic       busy_out, done_out, err_out;
   logic [3:0] sweep_cnt_out;

   int checks = 0;
   int passes = 0;

   counter_sweep_ctrl #(.PRESET_VAL(PRESET)) dut (
      .clk_in(clk),
      .rst_in(rst_in),
      .start_in(start_in),
      .abort_in(abort_in),
      .start_sel_in(start_sel_in),
      .lo_in(lo_in),
      .hi_in(hi_in),
      .cycles_in(cycles_in),
      .count_in(count),
      .cnt_rst_out(cnt_rst_out),
      .cnt_preset_out(cnt_preset_out),
      .cnt_updown_out(cnt_updown_out),
      .busy_out(busy_out),
      .done_out(done_out),
      .err_out(err_out),
      .sweep_cnt_out(sweep_cnt_out)
   );

   always #5 clk = ~clk;

   // the controlled counter
   always @(posedge clk) begin
      if (cnt_rst_out)
         count <= 10'd0;
      else if (cnt_preset_out)
         count <= PRESET;
      else if (cnt_updown_out)
         count <= count + 10'd1;
      else
         count <= count - 10'd1;
   end

   task automatic test_reset();
      checks++;
      if ({cnt_rst_out, cnt_preset_out, cnt_updown_out, busy_out,
           done_out, err_out, sweep_cnt_out} !== 10'b1000000000)
         $display("FAIL reset_hold got rst=%b pre=%b ud=%b busy=%b done=%b err=%b sw=%0d required 1 0 0 0 0 0 0",
                  cnt_rst_out, cnt_preset_out, cnt_updown_out, busy_out,
                  done_out, err_out, sweep_cnt_out);
      else passes++;
      rst_in = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({cnt_rst_out, busy_out, done_out, count} !== {1'b1, 1'b0, 1'b0, 10'd0})
         $display("FAIL idle_after_reset got rst=%b busy=%b done=%b count=%0d required 1 0 0 0",
                  cnt_rst_out, busy_out, done_out, count);
      else passes++;
      abort_in = 1'b1;
      @(posedge clk); #1;
      abort_in = 1'b0;
      checks++;
      if ({cnt_rst_out, busy_out, done_out, err_out} !== 4'b1000)
         $display("FAIL abort_in_idle got rst=%b busy=%b done=%b err=%b required 1 0 0 0",
                  cnt_rst_out, busy_out, done_out, err_out);
      else passes++;
   endtask

   task automatic run_sweep(input logic sel, input int lo, input int hi,
                            input int cyc, input int poke, input bit start_at_done);
      int traj[$];
      int v, last, sw;
      v = sel ? int'(PRESET) : 0;
      traj.push_back(v);
      for (int c = 0; c < cyc; c++) begin
         while (v < hi) begin v++; traj.push_back(v); end
         while (v > lo) begin v--; traj.push_back(v); end
      end
      last = traj.size() - 1;
      start_sel_in = sel;
      lo_in = 10'(lo);
      hi_in = 10'(hi);
      cycles_in = 4'(cyc);
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      checks++;
      if ({busy_out, done_out, err_out, sweep_cnt_out, count} !==
          {1'b1, 1'b0, 1'b0, 4'd0, 10'd0})
         $display("FAIL run_load got busy=%b done=%b err=%b sw=%0d count=%0d required 1 0 0 0 0",
                  busy_out, done_out, err_out, sweep_cnt_out, count);
      else passes++;
      sw = 0;
      for (int i = 0; i <= last; i++) begin
         if (i == poke) begin
            start_in = 1'b1;
            start_sel_in = 1'($urandom_range(0, 1));
            lo_in = 10'($urandom_range(0, 20));
            hi_in = 10'($urandom_range(300, 1023));
            cycles_in = 4'($urandom_range(1, 15));
         end
         @(posedge clk); #1;
         start_in = 1'b0;
         if (i > 0 && traj[i] == lo) sw++;
         checks++;
         if ({busy_out, done_out, err_out, sweep_cnt_out, count} !==
             {(i != last), (i == last), 1'b0, 4'(sw), 10'(traj[i])})
            $display("FAIL run_step%0d got busy=%b done=%b err=%b sw=%0d count=%0d required busy=%b done=%b sw=%0d count=%0d",
                     i, busy_out, done_out, err_out, sweep_cnt_out, count,
                     (i != last), (i == last), sw, traj[i]);
         else passes++;
      end
      if (start_at_done) begin
         start_in = 1'b1;
         start_sel_in = 1'b0;
         lo_in = 10'd0;
         hi_in = 10'd3;
         cycles_in = 4'd1;
      end
      @(posedge clk); #1;
      start_in = 1'b0;
      checks++;
      if ({busy_out, done_out, err_out, sweep_cnt_out, count, cnt_rst_out} !==
          {1'b0, 1'b0, 1'b0, 4'(cyc), 10'd0, 1'b1})
         $display("FAIL run_end got busy=%b done=%b err=%b sw=%0d count=%0d rst=%b required 0 0 0 %0d 0 1",
                  busy_out, done_out, err_out, sweep_cnt_out, count, cnt_rst_out, cyc);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if ({busy_out, done_out, count} !== {1'b0, 1'b0, 10'd0})
         $display("FAIL run_idle got busy=%b done=%b count=%0d required 0 0 0",
                  busy_out, done_out, count);
      else passes++;
   endtask

   task automatic test_reject(input logic sel, input int lo, input int hi, input int cyc);
      start_sel_in = sel;
      lo_in = 10'(lo);
      hi_in = 10'(hi);
      cycles_in = 4'(cyc);
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      checks++;
      if ({busy_out, done_out, err_out, sweep_cnt_out} !== {1'b0, 1'b1, 1'b1, 4'd0})
         $display("FAIL reject lo=%0d hi=%0d got busy=%b done=%b err=%b sw=%0d required 0 1 1 0",
                  lo, hi, busy_out, done_out, err_out, sweep_cnt_out);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if ({busy_out, done_out, err_out, count} !== {1'b0, 1'b0, 1'b0, 10'd0})
         $display("FAIL reject_after got busy=%b done=%b err=%b count=%0d required 0 0 0 0",
                  busy_out, done_out, err_out, count);
      else passes++;
   endtask

   task automatic start_zero_run(input int cyc);
      start_sel_in = 1'b0;
      lo_in = 10'd0;
      hi_in = 10'd3;
      cycles_in = 4'(cyc);
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
   endtask

   task automatic test_abort();
      start_zero_run(2);
      repeat (8) begin @(posedge clk); #1; end
      abort_in = 1'b1;
      @(posedge clk); #1;
      abort_in = 1'b0;
      checks++;
      if ({busy_out, done_out, cnt_rst_out, sweep_cnt_out} !== {1'b0, 1'b0, 1'b1, 4'd1})
         $display("FAIL abort_up2 got busy=%b done=%b rst=%b sw=%0d required 0 0 1 1",
                  busy_out, done_out, cnt_rst_out, sweep_cnt_out);
      else passes++;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({busy_out, done_out, sweep_cnt_out, count} !== {1'b0, 1'b0, 4'd1, 10'd0})
            $display("FAIL abort_quiet got busy=%b done=%b sw=%0d count=%0d required 0 0 1 0",
                     busy_out, done_out, sweep_cnt_out, count);
         else passes++;
      end
      start_zero_run(1);
      repeat (3) begin @(posedge clk); #1; end
      abort_in = 1'b1;
      @(posedge clk); #1;
      abort_in = 1'b0;
      checks++;
      if ({busy_out, cnt_rst_out, cnt_updown_out, done_out} !== 4'b0100)
         $display("FAIL abort_vs_turn got busy=%b rst=%b ud=%b done=%b required 0 1 0 0",
                  busy_out, cnt_rst_out, cnt_updown_out, done_out);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      start_zero_run(2);
      repeat (5) begin @(posedge clk); #1; end
      #3 rst_in = 1'b1;
      #1;
      checks++;
      if ({cnt_rst_out, cnt_preset_out, cnt_updown_out, busy_out,
           done_out, err_out, sweep_cnt_out} !== 10'b1000000000)
         $display("FAIL async_reset got rst=%b pre=%b ud=%b busy=%b done=%b err=%b sw=%0d required 1 0 0 0 0 0 0",
                  cnt_rst_out, cnt_preset_out, cnt_updown_out, busy_out,
                  done_out, err_out, sweep_cnt_out);
      else passes++;
      @(posedge clk); #1;
      rst_in = 1'b0;
      run_sweep(1'b0, 0, 3, 2, -1, 1'b0);
   endtask

   task automatic test_random_runs(input int n);
      logic sel;
      int lo, hi;
      for (int k = 0; k < n; k++) begin
         sel = 1'($urandom_range(0, 1));
         if (sel) begin
            lo = $urandom_range(213, 253);
            hi = $urandom_range(254, 290);
         end else begin
            lo = 0;
            hi = $urandom_range(1, 40);
         end
         run_sweep(sel, lo, hi, $urandom_range(1, 3),
                   $urandom_range(1, 10), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_random_rejects(input int n);
      int kind, lo, hi;
      for (int k = 0; k < n; k++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: begin
               lo = $urandom_range(0, 1023);
               hi = $urandom_range(0, lo);
               test_reject(1'($urandom_range(0, 1)), lo, hi, $urandom_range(1, 15));
            end
            1: begin
               lo = $urandom_range(0, 100);
               hi = $urandom_range(lo + 1, 253);
               test_reject(1'b1, lo, hi, $urandom_range(1, 15));
            end
            2: begin
               lo = $urandom_range(1, 500);
               hi = lo + 1 + $urandom_range(0, 100);
               test_reject(1'b0, lo, hi, $urandom_range(1, 15));
            end
            3: test_reject(1'b0, 0, $urandom_range(1, 1023), 0);
            default: begin
               lo = $urandom_range(254, 600);
               hi = lo + 1 + $urandom_range(0, 100);
               test_reject(1'b1, lo, hi, $urandom_range(1, 15));
            end
         endcase
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      run_sweep(1'b0, 0, 3, 2, -1, 1'b0);
      run_sweep(1'b1, 250, 255, 1, -1, 1'b0);
      test_reject(1'b0, 5, 5, 1);
      test_reject(1'b1, 100, 200, 1);
      test_reject(1'b0, 0, 3, 0);
      test_abort();
      test_async_reset();
      run_sweep(1'b0, 0, 3, 2, 2, 1'b1);
      run_sweep(1'b0, 0, 1, 2, -1, 1'b0);
      run_sweep(1'b1, 253, 254, 3, 1, 1'b0);
      test_random_runs(12);
      test_random_rejects(8);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter: PRESET_VAL, 253, preset value of the controlled 10-bit up/down counter; the start point when start_sel_in=1.
REQ-002 clk_in  input  1  single clock; all state changes on posedge clk_in.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 start_in  input  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-005 abort_in  input  1  terminates an active run.
REQ-006 start_sel_in  input  1  start point select: 0 = count 0 (counter reset), 1 = PRESET_VAL (counter preset).
REQ-007 lo_in  input  10  lower sweep bound; latched at accepted start.
REQ-008 hi_in  input  10  upper sweep bound; latched at accepted start.
REQ-009 cycles_in  input  4  number of sweeps, 1..15; latched at accepted start.
REQ-010 count_in  input  10  feedback from the counter's count output.
REQ-011 cnt_rst_out  output  1  drives counter synchronous reset.
REQ-012 cnt_preset_out  output  1  drives counter synchronous preset.
REQ-013 cnt_updown_out  output  1  drives counter direction (1 = up).
REQ-014 busy_out  output  1  high in LOAD, UP, DOWN.
REQ-015 done_out  output  1  one-cycle pulse at run completion or rejection.
REQ-016 err_out  output  1  one-cycle pulse, coincident with done_out, on rejected start.
REQ-017 sweep_cnt_out  output  4  completed sweeps in the current or last run.

Function
REQ-018 The controlled counter counts every clock unless reset/preset; all outputs are registered.
REQ-019 States: IDLE, LOAD, UP, DOWN, DONE.
REQ-020 IDLE: cnt_rst_out=1, cnt_preset_out=0, cnt_updown_out=0; the counter is pinned at 0.
REQ-021 Start valid iff lo_in < hi_in, lo_in <= S < hi_in (S = 0 or PRESET_VAL per start_sel_in), and cycles_in != 0.
REQ-022 Valid start in IDLE: latch lo/hi/cycles/sel, clear sweep_cnt_out, go LOAD; in LOAD, cnt_rst_out=~sel, cnt_preset_out=sel, cnt_updown_out=1.
REQ-023 Invalid start in IDLE: go DONE with done_out=1, err_out=1; remain non-busy; sweep_cnt_out=0.
REQ-024 LOAD lasts exactly one cycle, then UP with cnt_rst_out=0, cnt_preset_out=0, cnt_updown_out=1.
REQ-025 UP: at an edge where count_in == hi_q-1, set cnt_updown_out=0 and go DOWN; the counter holds hi_q for exactly one cycle.
REQ-026 DOWN: at an edge where count_in == lo_q+1, increment sweep_cnt_out; if the new value < cycles_q, set cnt_updown_out=1 and go UP.
REQ-027 DOWN, final sweep (new sweep_cnt_out == cycles_q): set cnt_rst_out=1 and go DONE; done_out=1 while the counter shows lo_q; the counter reads 0 one cycle later.
REQ-028 DONE lasts one cycle, then IDLE; done_out/err_out are low in every other state.
REQ-029 abort_in in LOAD/UP/DOWN: next edge goes to IDLE with IDLE output values; no done_out; sweep_cnt_out keeps its value.
REQ-030 start_in while busy or in DONE is ignored; abort_in in IDLE/DONE is ignored.
REQ-031 abort_in and a turn condition in the same cycle: abort wins.
REQ-032 Bound comparisons are unsigned 10-bit; hi_q-1 and lo_q+1 cannot wrap because lo_q < hi_q.

Reset
REQ-033 rst_in=1 forces, without waiting for a clock edge: state IDLE, cnt_rst_out=1, cnt_preset_out=0, cnt_updown_out=0, busy_out=0, done_out=0, err_out=0, sweep_cnt_out=0, latched bounds=0.
REQ-034 Reset mid-run abandons the run silently; after rst_in falls, the first start_in is accepted normally.

Verification
REQ-035 Zero start: sel=0, lo=0, hi=3, cycles=2 -> count_in 0,1,2,3,2,1,0,1,2,3,2,1,0; done_out with count 0; sweep_cnt_out=2; then IDLE.
REQ-036 Preset start: sel=1, lo=250, hi=255, cycles=1 -> count_in 253,254,255,254,253,252,251,250; done_out at 250; next count 0.
REQ-037 Rejects: lo=5, hi=5 -> done_out=err_out=1 one cycle after start; busy_out never high. sel=1, hi=200 -> same. cycles=0 -> same.
REQ-038 Abort: abort_in during the second UP leg -> busy_out=0 and cnt_rst_out=1 next cycle; no done_out; sweep_cnt_out=1.
REQ-039 Async reset mid-DOWN: assert rst_in between edges -> outputs at reset values before the next edge; a restart runs the REQ-035 trace exactly.
REQ-040 start_in pulsed in UP with different bounds -> ignored; the run completes with the original bounds.
